// File: rtl/barrel_shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: shift-mode encodings.
package barrel_shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_LSR = 2'b00;
    localparam mode_t MODE_ASR = 2'b01;
    localparam mode_t MODE_LSL = 2'b10;
    localparam mode_t MODE_ROR = 2'b11;

endpackage

// File: rtl/barrel_shift_stage.sv
// One barrel-shifter level: conditional shift by 2**STAGE_IDX, with guard/sticky
// tracking for right shifts, plus its payload register and valid/load handshake.
module barrel_shift_stage
    import barrel_shift_pkg::*;
#(
    parameter  int DATA_W    = 8,
    parameter  int SHAMT_W   = $clog2(DATA_W),
    parameter  int STAGE_IDX = 0,
    localparam int PAY_W     = DATA_W + SHAMT_W + 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid_i,
    input  logic [PAY_W-1:0] up_pay_i,
    input  logic             take_i,
    output logic             load_o,
    output logic             valid_o,
    output logic [PAY_W-1:0] pay_o
);

    localparam int SHIFT = 1 << STAGE_IDX;
    localparam logic [DATA_W-1:0] LOW_MASK = (DATA_W'(1) << (SHIFT - 1)) - DATA_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        mode_t              mode;
        logic               guard;
        logic               sticky;
    } payload_t;

    function automatic payload_t shift_level(input payload_t p);
        payload_t                  r;
        logic signed [DATA_W-1:0]  sdata;
        r     = p;
        sdata = p.data;
        if (p.shamt[STAGE_IDX]) begin
            case (p.mode)
                MODE_LSR: r.data = p.data >> SHIFT;
                MODE_ASR: r.data = $unsigned(sdata >>> SHIFT);
                MODE_LSL: r.data = p.data << SHIFT;
                default:  r.data = (p.data >> SHIFT) | (p.data << (DATA_W - SHIFT));
            endcase
            // The previous guard drops into sticky; the new guard is the last bit out.
            if (p.mode == MODE_LSR || p.mode == MODE_ASR) begin
                r.guard  = p.data[SHIFT-1];
                r.sticky = p.sticky | p.guard | (|(p.data & LOW_MASK));
            end
        end
        if (p.mode == MODE_LSL || p.mode == MODE_ROR) begin
            r.guard  = 1'b0;
            r.sticky = 1'b0;
        end
        return r;
    endfunction

    payload_t up_pay;
    payload_t pay_d, pay_q;
    logic     valid_d, valid_q;

    assign up_pay = up_pay_i;
    assign load_o = !valid_q || take_i;

    always_comb begin
        valid_d = valid_q;
        pay_d   = pay_q;
        if (load_o) begin
            valid_d = up_valid_i;
            if (up_valid_i) begin
                pay_d = shift_level(up_pay);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pay_q   <= pay_d;
        end
    end

    assign valid_o = valid_q;
    assign pay_o   = pay_q;

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter (LSR/ASR/LSL/ROR) with guard/sticky for the rounder;
// one register stage per shift level, valid/ready handshake on both sides.
module barrel_shifter_pipe
    import barrel_shift_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_guard,
    output logic               out_sticky
);

    localparam int PAY_W = DATA_W + SHAMT_W + 4;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic [SHAMT_W-1:0] shamt;
        mode_t              mode;
        logic               guard;
        logic               sticky;
    } payload_t;

    logic [SHAMT_W:0]            vld;
    logic [SHAMT_W:0][PAY_W-1:0] pay;
    logic [SHAMT_W-1:0]          load;
    logic [SHAMT_W-1:0]          take;
    payload_t                    in_pay;
    payload_t                    out_pay;
    logic                        alive_q;
    logic                        unused_ctrl;

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign in_ready = alive_q && load[0];

    always_comb begin
        in_pay        = '0;
        in_pay.data   = in_data;
        in_pay.shamt  = in_shamt;
        in_pay.mode   = in_mode;
    end

    assign vld[0] = in_valid && in_ready;
    assign pay[0] = in_pay;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        if (k < SHAMT_W - 1) begin : g_mid
            assign take[k] = load[k+1];
        end else begin : g_last
            assign take[k] = out_ready;
        end

        barrel_shift_stage #(
            .DATA_W    (DATA_W),
            .SHAMT_W   (SHAMT_W),
            .STAGE_IDX (k)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid_i (vld[k]),
            .up_pay_i   (pay[k]),
            .take_i     (take[k]),
            .load_o     (load[k]),
            .valid_o    (vld[k+1]),
            .pay_o      (pay[k+1])
        );
    end

    assign out_pay     = pay[SHAMT_W];
    assign out_valid   = vld[SHAMT_W];
    assign out_data    = out_pay.data;
    assign out_guard   = out_pay.guard;
    assign out_sticky  = out_pay.sticky;
    assign unused_ctrl = ^{out_pay.shamt, out_pay.mode};

    // A stalled result must not change until the consumer takes it.
    out_hold_a: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready) |=> (out_valid && $stable({out_data, out_guard, out_sticky})));

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Directed bench for barrel_shifter_pipe (DATA_W = 8): single shifts per mode,
// backpressure, full-rate streaming and asynchronous reset mid-stream.
module tb_barrel_shifter_pipe;
    import barrel_shift_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic [2:0] in_shamt = 3'd0;
    logic [1:0] in_mode = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_guard;
    logic       out_sticky;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] bp_d [6] = '{8'hF0, 8'h80, 8'h01, 8'h12, 8'hFF, 8'h7F};
    logic [2:0] bp_s [6] = '{3'd4, 3'd1, 3'd7, 3'd4, 3'd2, 3'd5};
    logic [1:0] bp_m [6] = '{MODE_LSR, MODE_ASR, MODE_LSL, MODE_ROR, MODE_LSR, MODE_ASR};
    logic [7:0] bp_e [6] = '{8'h0F, 8'hC0, 8'h80, 8'h21, 8'h3F, 8'h03};
    logic       bp_g [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       bp_k [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    barrel_shifter_pipe #(.DATA_W(8), .SHAMT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_guard  (out_guard),
        .out_sticky (out_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] s, input logic [1:0] m);
        in_valid = v;
        in_data  = d;
        in_shamt = s;
        in_mode  = m;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d, input logic g, input logic k);
        check({tag, "_vld"},    32'(out_valid),  32'd1);
        check({tag, "_data"},   32'(out_data),   32'(d));
        check({tag, "_guard"},  32'(out_guard),  32'(g));
        check({tag, "_sticky"}, 32'(out_sticky), 32'(k));
    endtask

    task automatic single(input string tag, input logic [7:0] d, input logic [2:0] s,
                          input logic [1:0] m, input logic [7:0] e, input logic g, input logic k);
        int lat;
        drive(1'b1, d, s, m);
        #1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        expect_out(tag, e, g, k);
        step();
    endtask

    initial begin
        int         sent;
        logic [7:0] tmp;

        // Reset state while rst_n is low
        #12;
        check("rst_vld",    32'(out_valid),  32'd0);
        check("rst_data",   32'(out_data),   32'd0);
        check("rst_guard",  32'(out_guard),  32'd0);
        check("rst_sticky", 32'(out_sticky), 32'd0);
        check("rst_rdy",    32'(in_ready),   32'd0);
        #10;
        rst_n = 1'b1;
        step();
        check("rel_rdy", 32'(in_ready), 32'd1);
        out_ready = 1'b1;

        single("lsr_b5_1", 8'hB5, 3'd1, MODE_LSR, 8'h5A, 1'b1, 1'b0);
        single("asr_b5_3", 8'hB5, 3'd3, MODE_ASR, 8'hF6, 1'b1, 1'b1);
        single("asr_40_7", 8'h40, 3'd7, MODE_ASR, 8'h00, 1'b1, 1'b0);
        single("lsl_b5_4", 8'hB5, 3'd4, MODE_LSL, 8'h50, 1'b0, 1'b0);
        single("ror_81_1", 8'h81, 3'd1, MODE_ROR, 8'hC0, 1'b0, 1'b0);
        single("asr_3c_0", 8'h3C, 3'd0, MODE_ASR, 8'h3C, 1'b0, 1'b0);

        // Backpressure: out_ready low for 5 cycles while streaming 6 beats
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bp_d[i], bp_s[i], bp_m[i]);
            #1;
            check("bp_fill_rdy", 32'(in_ready), 32'd1);
            step();
        end
        sent = 3;
        drive(1'b1, bp_d[3], bp_s[3], bp_m[3]);
        for (int i = 0; i < 2; i++) begin
            #1;
            check("bp_stall_rdy",  32'(in_ready),  32'd0);
            check("bp_stall_vld",  32'(out_valid), 32'd1);
            check("bp_stall_data", 32'(out_data),  32'(bp_e[0]));
            step();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            if (sent < 6) drive(1'b1, bp_d[sent], bp_s[sent], bp_m[sent]);
            else          in_valid = 1'b0;
            #1;
            expect_out("bp_drain", bp_e[j], bp_g[j], bp_k[j]);
            if (in_valid) begin
                check("bp_drain_rdy", 32'(in_ready), 32'd1);
                sent++;
            end
            step();
        end
        in_valid = 1'b0;
        #1;
        check("bp_empty_vld", 32'(out_valid), 32'd0);

        // Full-rate streaming: LSL by 1 of 3*t+1 for 20 beats
        for (int t = 0; t < 23; t++) begin
            if (t < 20) drive(1'b1, 8'(t * 3 + 1), 3'd1, MODE_LSL);
            else        in_valid = 1'b0;
            #1;
            if (t < 20) check("full_rdy", 32'(in_ready), 32'd1);
            if (t >= 3) begin
                tmp = 8'((t - 3) * 3 + 1);
                check("full_vld",  32'(out_valid), 32'd1);
                check("full_data", 32'(out_data),  32'({tmp[6:0], 1'b0}));
            end else begin
                check("full_fill_vld", 32'(out_valid), 32'd0);
            end
            step();
        end

        // Asynchronous reset with two beats in flight
        drive(1'b1, 8'h11, 3'd0, MODE_LSR);
        step();
        drive(1'b1, 8'h22, 3'd0, MODE_LSR);
        step();
        in_valid = 1'b0;
        step();
        check("mid_pre_vld", 32'(out_valid), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_vld",  32'(out_valid), 32'd0);
        check("mid_rst_data", 32'(out_data),  32'd0);
        check("mid_rst_rdy",  32'(in_ready),  32'd0);
        step();
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) check("mid_rel_rdy", 32'(in_ready), 32'd1);
            check("mid_post_vld", 32'(out_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
